// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: state encoding, strobe levels and counter sizing
// helpers for the sram_controller bus master.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // the counter only ever holds n-1, so $clog2(n) bits suffice
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: valid/ready to async SRAM sequencer (setup/strobe/hold).
// Optional read->write bus turnaround cycle: SRAM_CTRL_TURNAROUND_EN.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 15,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  chip_enable,
  output logic                  write_enable,
  output logic                  output_enable
);

  localparam int MAXC = max3(SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES);
  localparam int CW   = cnt_width(MAXC);

  if (SETUP_CYCLES < 1 || ACCESS_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad
    $error("sram_controller: cycle parameters must be >= 1");
  end

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  write_op;
  logic                  drive;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  accept;
  logic                  turn;

  assign req_ready = reset_n && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign data      = drive ? wdata : {DATA_WIDTH{1'bz}};

`ifdef SRAM_CTRL_TURNAROUND_EN
  // write_op still holds the op that just finished while resp_valid is high
  assign turn = req_write && resp_valid && !write_op;
`else
  assign turn = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      write_op      <= 1'b0;
      drive         <= 1'b0;
      wdata         <= '0;
      address       <= '0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      chip_enable   <= STROBE_OFF;
      write_enable  <= STROBE_OFF;
      output_enable <= STROBE_OFF;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            write_op <= req_write;
            address  <= req_address;
            wdata    <= req_wdata;
            if (turn) begin
              state <= S_TURN;
            end else begin
              state       <= S_SETUP;
              cnt         <= CW'(SETUP_CYCLES - 1);
              chip_enable <= STROBE_ON;
              drive       <= req_write;
            end
          end
        end
        S_TURN: begin
          state       <= S_SETUP;
          cnt         <= CW'(SETUP_CYCLES - 1);
          chip_enable <= STROBE_ON;
          drive       <= write_op;
        end
        S_SETUP: begin
          if (cnt == '0) begin
            state         <= S_ACCESS;
            cnt           <= CW'(ACCESS_CYCLES - 1);
            write_enable  <= write_op ? STROBE_ON : STROBE_OFF;
            output_enable <= write_op ? STROBE_OFF : STROBE_ON;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            state         <= S_HOLD;
            cnt           <= CW'(HOLD_CYCLES - 1);
            write_enable  <= STROBE_OFF;
            output_enable <= STROBE_OFF;
            if (!write_op) resp_rdata <= data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state       <= S_IDLE;
            chip_enable <= STROBE_OFF;
            drive       <= 1'b0;
            resp_valid  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
